gcd_driver: RTL and testbench
=============================

GCD_DRIVER -- requirements
Module: gcd_driver

Interface
REQ-001 Parameter WIDTH, 16, operand/result width in bits.
REQ-002 Parameter TIMEOUT, 1024, maximum WAIT cycles before abort (>=2).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  driver can accept a pair.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 gcd_clr  output  1  one-cycle clear pulse to the GCD core.
REQ-010 gcd_start  output  1  start strobe to the GCD core.
REQ-011 gcd_data_in  output  WIDTH  shared operand bus to the GCD core.
REQ-012 gcd_done  input  1  GCD core done; stays high until the core is cleared.
REQ-013 gcd_result  input  WIDTH  GCD core result; valid while gcd_done=1.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 out_result  output  WIDTH  GCD result.
REQ-017 out_err  output  1  invalid input (0,0) or timeout; qualifies out_result.

Function
REQ-018 The block SHALL implement the states IDLE, CLEAR, LOAD_A, LOAD_B, WAIT and OUT.
REQ-019 IDLE: in_ready=1; on in_valid=1, the block SHALL register in_a and in_b and leave IDLE on the next edge.
REQ-020 In all states other than IDLE, in_ready SHALL be 0.
REQ-021 Zero bypass: if exactly one captured operand is 0, the block SHALL go IDLE->OUT with out_result set to the nonzero operand and out_err=0, without driving the core.
REQ-022 If both operands are 0, the block SHALL go IDLE->OUT with out_result=0 and out_err=1.
REQ-023 Otherwise the block SHALL go IDLE->CLEAR.
REQ-024 CLEAR: gcd_clr=1 for exactly one cycle; then ->LOAD_A.
REQ-025 LOAD_A: gcd_start=1 and gcd_data_in=A for exactly one cycle; then ->LOAD_B.
REQ-026 LOAD_B: gcd_data_in=B and gcd_start=0 for exactly one cycle; then ->WAIT with the timeout counter cleared to 0.
REQ-027 Outside LOAD_A and LOAD_B, gcd_data_in SHALL be 0.
REQ-028 gcd_clr and gcd_start SHALL be 0 outside CLEAR and LOAD_A respectively.
REQ-029 gcd_done SHALL be sampled only in WAIT and ignored in all other states.
REQ-030 WAIT: gcd_done=1 SHALL capture gcd_result into out_result, set out_err=0 and go ->OUT.
REQ-031 WAIT: each cycle without done SHALL increment the counter (ceil(log2(TIMEOUT+1)) bits, no wrap).
REQ-032 When the counter reaches TIMEOUT-1 with gcd_done=0, the block SHALL go ->OUT with out_result=0 and out_err=1.
REQ-033 If done and the timeout coincide, done SHALL take priority.
REQ-034 OUT: out_valid=1; out_result and out_err SHALL be held stable until the cycle in which out_ready=1, then the block SHALL go ->IDLE.
REQ-035 out_valid SHALL be 0 in all states except OUT.
REQ-036 Latency, core path: with accept at edge 0, CLEAR at 1, LOAD_A at 2, LOAD_B at 3, WAIT from 4; out_valid SHALL rise on the edge after gcd_done is sampled high.
REQ-037 Latency, bypass path: out_valid SHALL be 1 in the cycle after acceptance.
REQ-038 Back-to-back operation: a new pair SHALL be accepted no earlier than the cycle after the OUT handshake; every core-path transaction SHALL issue gcd_clr.

Reset
REQ-039 While rst_n=0, the block SHALL be forced asynchronously to IDLE.
REQ-040 Reset values: state IDLE; in_ready=1; gcd_clr, gcd_start, out_valid and out_err = 0; gcd_data_in, out_result, counter and operand registers = 0.
REQ-041 Reset asserted mid-operation SHALL abandon the transaction with no output produced; the first post-reset transaction SHALL operate normally.

Verification
REQ-042 Pair (48,18), core returns 6 on done in the 5th WAIT cycle -> gcd_clr at edge 1, start with data 48 at edge 2, data 18 at edge 3, out_result=6, out_err=0.
REQ-043 Pair (0,25) -> no gcd_clr or gcd_start; out_valid in the next cycle with out_result=25, out_err=0.
REQ-044 Pair (0,0) -> out_result=0, out_err=1, core untouched.
REQ-045 TIMEOUT=8 with gcd_done held 0 -> exactly 8 WAIT cycles, then out_valid=1, out_result=0, out_err=1.
REQ-046 out_ready held 0 for 5 cycles in OUT -> out_valid, out_result and out_err stable throughout, in_ready=0; in_ready=1 the cycle after the handshake.
REQ-047 rst_n pulsed low during WAIT -> all outputs at reset values immediately; next pair (35,14) -> out_result=7.

Source files
------------

// File: rtl/gcd_driver_if.sv
// Handshake and core-side signal bundle for gcd_driver.
// The master modport is the driver's own view: it accepts operand pairs,
// drives the GCD core and presents results. The slave modport is the
// view of everything around it (upstream source, core and result sink).
interface gcd_driver_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             gcd_clr;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_data_in;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_err;

  modport master (
    input  in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
    output in_ready, gcd_clr, gcd_start, gcd_data_in, out_valid, out_result, out_err
  );

  modport slave (
    output in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
    input  in_ready, gcd_clr, gcd_start, gcd_data_in, out_valid, out_result, out_err
  );
endinterface

// File: rtl/gcd_driver.sv
// gcd_driver: sequences one operand pair through an external GCD core.
// Pairs with a zero operand are answered directly without touching the core.
// The core is cleared, loaded with A (with start) then B over the shared
// bus, and the result is awaited with a bounded timeout. All outputs are
// registered and decoded from the next state, so each output is a clean
// flop that changes together with the state it belongs to.
module gcd_driver #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  gcd_driver_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_WAIT   = 3'd4,
    ST_OUT    = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] op_a_r, op_a_s;
  logic [WIDTH-1:0] op_b_r, op_b_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic             err_r, err_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic             in_ready_r, gcd_clr_r, gcd_start_r, out_valid_r;

  // Next-state, operand capture, timeout counter and result selection.
  always_comb begin
    state_s  = state_r;
    op_a_s   = op_a_r;
    op_b_s   = op_b_r;
    cnt_s    = cnt_r;
    result_s = result_r;
    err_s    = err_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_a_s = bus.in_a;
          op_b_s = bus.in_b;
          if ((bus.in_a == {WIDTH{1'b0}}) && (bus.in_b == {WIDTH{1'b0}})) begin
            state_s  = ST_OUT;
            result_s = {WIDTH{1'b0}};
            err_s    = 1'b1;
          end else if (bus.in_a == {WIDTH{1'b0}}) begin
            state_s  = ST_OUT;
            result_s = bus.in_b;
            err_s    = 1'b0;
          end else if (bus.in_b == {WIDTH{1'b0}}) begin
            state_s  = ST_OUT;
            result_s = bus.in_a;
            err_s    = 1'b0;
          end else begin
            state_s = ST_CLEAR;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR:  state_s = ST_LOAD_A;
      ST_LOAD_A: state_s = ST_LOAD_B;
      ST_LOAD_B: begin
        state_s = ST_WAIT;
        cnt_s   = {CW{1'b0}};
      end
      ST_WAIT: begin
        // A done seen on the last allowed cycle still wins over the timeout.
        if (bus.gcd_done) begin
          state_s  = ST_OUT;
          result_s = bus.gcd_result;
          err_s    = 1'b0;
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          state_s  = ST_OUT;
          result_s = {WIDTH{1'b0}};
          err_s    = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Core bus value for the upcoming state: A while loading A, B while loading B, else 0.
  always_comb begin
    data_s = {WIDTH{1'b0}};
    case (state_s)
      ST_LOAD_A: data_s = op_a_s;
      ST_LOAD_B: data_s = op_b_s;
      default:   data_s = {WIDTH{1'b0}};
    endcase
  end

  // State, datapath and registered outputs; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      op_a_r      <= {WIDTH{1'b0}};
      op_b_r      <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      err_r       <= 1'b0;
      data_r      <= {WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      gcd_clr_r   <= 1'b0;
      gcd_start_r <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      op_a_r      <= op_a_s;
      op_b_r      <= op_b_s;
      cnt_r       <= cnt_s;
      result_r    <= result_s;
      err_r       <= err_s;
      data_r      <= data_s;
      in_ready_r  <= (state_s == ST_IDLE);
      gcd_clr_r   <= (state_s == ST_CLEAR);
      gcd_start_r <= (state_s == ST_LOAD_A);
      out_valid_r <= (state_s == ST_OUT);
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.gcd_clr     = gcd_clr_r;
  assign bus.gcd_start   = gcd_start_r;
  assign bus.gcd_data_in = data_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_result  = result_r;
  assign bus.out_err     = err_r;

endmodule

// File: tb/tb_gcd_driver.sv
// Directed bench for gcd_driver (TIMEOUT=8). A pin-level GCD core model
// answers after a programmable number of WAIT cycles; a scoreboard of
// arithmetic expectations is compared against the result port every cycle
// out_valid is high, and each transaction's latencies are pinned to
// hand-computed constants.
module tb_gcd_driver;

  localparam int W  = 16;
  localparam int TO = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // core model state
  int           core_delay = 0;
  int           core_phase = 0;
  int           core_cnt = 0;
  logic [W-1:0] core_a, core_b;

  // per-transaction observations, relative to the accept edge
  int           clr_n, start_n, clr_rel, start_rel, valid_rel, bus_bad, ready_bad;
  logic [W-1:0] d1, d2, res_v;
  logic         err_v;

  gcd_driver_if #(.WIDTH(W)) bus_if ();

  gcd_driver #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.master)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  // Expected outcome from the operands and how many WAIT cycles the core takes (0 = never).
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int delay);
    exp_t e;
    if (a == 0 && b == 0) begin e.res = 0; e.err = 1'b1; end
    else if (a == 0)      begin e.res = b; e.err = 1'b0; end
    else if (b == 0)      begin e.res = a; e.err = 1'b0; end
    else if (delay == 0 || delay > TO) begin e.res = 0; e.err = 1'b1; end
    else                  begin e.res = ref_gcd(a, b); e.err = 1'b0; end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // GCD core: clear, load A with start, load B, then done after core_delay cycles.
  task automatic core_model();
    forever begin
      @(posedge clk); #1;
      if (bus_if.gcd_clr) begin
        core_phase = 0; bus_if.gcd_done = 1'b0; bus_if.gcd_result = '0;
      end else if (bus_if.gcd_start) begin
        core_a = bus_if.gcd_data_in; core_phase = 1;
      end else if (core_phase == 1) begin
        core_b = bus_if.gcd_data_in; core_phase = 2; core_cnt = 0;
      end else if (core_phase == 2 && !bus_if.gcd_done) begin
        core_cnt++;
        if (core_delay != 0 && core_cnt == core_delay) begin
          bus_if.gcd_done = 1'b1; bus_if.gcd_result = ref_gcd(core_a, core_b);
        end
      end
    end
  endtask

  // Scoreboard compare on every cycle a result is presented.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (rst_n && bus_if.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 0, 1);
        end else begin
          chk("sb_result", bus_if.out_result, exp_q[0].res);
          chk("sb_err", bus_if.out_err, exp_q[0].err);
          chk("sb_in_ready_low", bus_if.in_ready, 0);
          if (bus_if.out_ready) exp_q.delete(0);
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, bus_if.in_ready, 1);
    chk({tag, "_gcd_clr"}, bus_if.gcd_clr, 0);
    chk({tag, "_gcd_start"}, bus_if.gcd_start, 0);
    chk({tag, "_gcd_data_in"}, bus_if.gcd_data_in, 0);
    chk({tag, "_out_valid"}, bus_if.out_valid, 0);
    chk({tag, "_out_result"}, bus_if.out_result, 0);
    chk({tag, "_out_err"}, bus_if.out_err, 0);
  endtask

  // One full transaction: offer the pair, observe the core bus, hold out_ready low, handshake.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int delay, input int hold);
    int n, rel;
    logic acc;
    @(posedge clk); #1;
    core_delay = delay;
    exp_q.push_back(model(a, b, delay));
    bus_if.in_a = a; bus_if.in_b = b; bus_if.in_valid = 1'b1; bus_if.out_ready = 1'b0;
    n = 0; acc = 1'b0;
    while (!acc && n < 20) begin
      @(negedge clk); acc = bus_if.in_ready;
      @(posedge clk); #1; n++;
    end
    bus_if.in_valid = 1'b0; bus_if.in_a = '0; bus_if.in_b = '0;
    if (!acc) chk("accept_timeout", 0, 1);
    rel = 0; clr_n = 0; start_n = 0; clr_rel = -1; start_rel = -1; valid_rel = -1;
    bus_bad = 0; ready_bad = 0; d1 = '0; d2 = '0; res_v = '0; err_v = 1'b0;
    while (valid_rel < 0 && rel < 40) begin
      @(negedge clk);
      if (bus_if.gcd_clr)   begin clr_n++; clr_rel = rel; end
      if (bus_if.gcd_start) begin start_n++; start_rel = rel; end
      if (rel == 1) d1 = bus_if.gcd_data_in;
      else if (rel == 2) d2 = bus_if.gcd_data_in;
      else if (bus_if.gcd_data_in != 0) bus_bad++;
      if (bus_if.in_ready) ready_bad++;
      if (bus_if.out_valid) begin
        valid_rel = rel; res_v = bus_if.out_result; err_v = bus_if.out_err;
      end else begin
        @(posedge clk); #1; rel++;
      end
    end
    if (valid_rel < 0) chk("out_valid_timeout", 0, 1);
    chk("bus_idle_zero", bus_bad, 0);
    chk("in_ready_low_busy", ready_bad, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_out_valid", bus_if.out_valid, 1);
      chk("hold_in_ready", bus_if.in_ready, 0);
      chk("hold_result", bus_if.out_result, res_v);
      chk("hold_err", bus_if.out_err, err_v);
    end
    @(posedge clk); #1; bus_if.out_ready = 1'b1;
    @(posedge clk); #1; bus_if.out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_in_ready", bus_if.in_ready, 1);
    chk("post_hs_out_valid", bus_if.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus_if.in_valid = 1'b0; bus_if.in_a = '0; bus_if.in_b = '0;
    bus_if.out_ready = 1'b0; bus_if.gcd_done = 1'b0; bus_if.gcd_result = '0;
    fork
      core_model();
      compare_loop();
    join_none
    repeat (3) @(posedge clk);
    #1; check_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk); check_reset_values("post_rst");

    // core path, done in the 5th WAIT cycle
    run_txn(16'd48, 16'd18, 5, 0);
    chk("t1_clr_rel", clr_rel, 0);     chk("t1_clr_n", clr_n, 1);
    chk("t1_start_rel", start_rel, 1); chk("t1_start_n", start_n, 1);
    chk("t1_data_a", d1, 48);          chk("t1_data_b", d2, 18);
    chk("t1_valid_rel", valid_rel, 8);
    chk("t1_result", res_v, 6);        chk("t1_err", err_v, 0);

    // zero bypass, both orders, and the (0,0) error
    run_txn(16'd0, 16'd25, 5, 0);
    chk("t2_clr_n", clr_n, 0); chk("t2_start_n", start_n, 0);
    chk("t2_valid_rel", valid_rel, 0); chk("t2_result", res_v, 25); chk("t2_err", err_v, 0);
    run_txn(16'd40, 16'd0, 5, 0);
    chk("t3_clr_n", clr_n, 0); chk("t3_result", res_v, 40); chk("t3_err", err_v, 0);
    run_txn(16'd0, 16'd0, 5, 0);
    chk("t4_clr_n", clr_n, 0); chk("t4_start_n", start_n, 0);
    chk("t4_valid_rel", valid_rel, 0); chk("t4_result", res_v, 0); chk("t4_err", err_v, 1);

    // timeout: 8 WAIT cycles, then error
    run_txn(16'd77, 16'd91, 0, 0);
    chk("t5_clr_n", clr_n, 1); chk("t5_valid_rel", valid_rel, 11);
    chk("t5_result", res_v, 0); chk("t5_err", err_v, 1);

    // done on the last allowed WAIT cycle beats the timeout
    run_txn(16'd21, 16'd14, 8, 0);
    chk("t6_valid_rel", valid_rel, 11); chk("t6_result", res_v, 7); chk("t6_err", err_v, 0);

    // fastest core, out_ready held low for 5 cycles
    run_txn(16'd12, 16'd18, 1, 5);
    chk("t7_valid_rel", valid_rel, 4); chk("t7_result", res_v, 6); chk("t7_clr_n", clr_n, 1);

    // wide and equal operands
    run_txn(16'hFFFF, 16'd4369, 2, 1);
    chk("t8_result", res_v, 4369);
    run_txn(16'd17, 16'd17, 3, 0);
    chk("t9_result", res_v, 17); chk("t9_valid_rel", valid_rel, 6);

    // reset pulse while waiting on the core abandons the pair
    @(posedge clk); #1;
    core_delay = 0;
    bus_if.in_a = 16'd100; bus_if.in_b = 16'd75; bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0; bus_if.in_a = '0; bus_if.in_b = '0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_rst");
    exp_q.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("after_rst_no_valid", bus_if.out_valid, 0);
      chk("after_rst_in_ready", bus_if.in_ready, 1);
    end
    run_txn(16'd35, 16'd14, 3, 0);
    chk("t10_clr_n", clr_n, 1); chk("t10_valid_rel", valid_rel, 6);
    chk("t10_result", res_v, 7); chk("t10_err", err_v, 0);

    repeat (3) @(posedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
